// File: rtl/sub_ctrl_pkg.sv
// Shared constants and types for the shared-subtractor controller.
//   DATA_W  : operand / result width
//   state_e : controller FSM states
package sub_ctrl_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/borrow_select_subtractor.sv
// Combinational a - b built from borrow-select blocks: every block computes
// its difference for borrow-in 0 and 1 in parallel, and the incoming borrow
// only drives a mux.
//   a_i, b_i  : minuend, subtrahend
//   diff_o    : a - b modulo 2^W
//   borrow_o  : borrow out of the MSB (a < b unsigned)
//   ov_o      : signed overflow
module borrow_select_subtractor #(
    parameter int W   = 16,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o,
    output logic         ov_o
);

    localparam int NB = W / BLK;

    logic [NB:0] bin;

    assign bin[0] = 1'b0;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [BLK:0] d0;
        logic [BLK:0] d1;

        // The extra MSB of each BLK+1-bit result is the block borrow-out.
        assign d0 = {1'b0, a_i[k*BLK +: BLK]} - {1'b0, b_i[k*BLK +: BLK]};
        assign d1 = d0 - (BLK+1)'(1);

        assign diff_o[k*BLK +: BLK] = bin[k] ? d1[BLK-1:0] : d0[BLK-1:0];
        assign bin[k+1]             = bin[k] ? d1[BLK]     : d0[BLK];
    end

    assign borrow_o = bin[NB];
    assign ov_o     = (a_i[W-1] ^ b_i[W-1]) & (diff_o[W-1] ^ a_i[W-1]);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector, one bit per requester
//   ptr    : index of the requester granted last; search starts at ptr+1
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : binary index of the granted requester (0 when no request)
module rr_arbiter
    import sub_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic found;
    int   idx;

    // Walk ptr+1 .. ptr+NUM_REQ; the last step wraps back to ptr itself,
    // so the previous winner only wins again if nobody else is asking.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sub_share_ctrl.sv
// Shares one borrow_select_subtractor among NUM_REQ valid/ready requesters
// with round-robin arbitration and a single backpressured response bus.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester operand valid
//   req_ready    : one-hot grant, only in IDLE
//   req_a, req_b : packed operands, requester i at [16*i +: 16]
//   rsp_valid    : result valid (RESP state)
//   rsp_ready    : consumer accepts result
//   rsp_result   : a - b modulo 2^16
//   rsp_overflow : signed overflow of a - b
//   rsp_id       : requester owning the result
//   busy         : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; grant and capture operands in one cycle
// CALC  | registered operands through the subtractor; capture result
// RESP  | present result until rsp_ready
module sub_share_ctrl
    import sub_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_overflow,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                ov_q, ov_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [DATA_W-1:0]   diff;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Overflow is derived locally from the registered operands, so the
    // subtractor's own flags are not used.
    borrow_select_subtractor #(.W(DATA_W), .BLK(4)) u_sub (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .diff_o   (diff),
        .borrow_o (),
        .ov_o     ()
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        ov_d      = ov_q;
        req_ready = '0;

        unique case (state_q)
            IDLE: begin
                // Reset wins over a same-cycle grant: nothing is accepted.
                if (|req_valid && !rst) begin
                    req_ready = gnt;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            op_a_d = req_a[i*DATA_W +: DATA_W];
                            op_b_d = req_b[i*DATA_W +: DATA_W];
                        end
                    end
                    id_d    = gnt_id;
                    ptr_d   = gnt_id;
                    state_d = CALC;
                end
            end
            CALC: begin
                res_d   = diff;
                ov_d    = (op_a_q[DATA_W-1] ^ op_b_q[DATA_W-1]) &
                          (diff[DATA_W-1] ^ op_a_q[DATA_W-1]);
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

    assign rsp_valid    = (state_q == RESP);
    assign rsp_result   = res_q;
    assign rsp_overflow = ov_q;
    assign rsp_id       = id_q;
    assign busy         = (state_q != IDLE);

endmodule
